// File: rtl/sub8_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
//   state_t : controller state encoding (IDLE, RUN, DONE)
//   digits(): number of RUN cycles needed to consume a full operand
package sub8_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int digits(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/serial_sub8_sub_digit.sv
// Combinational DIGIT-bit subtract cell with borrow chain.
//   x, y : DIGIT-bit minuend / subtrahend slices
//   bin  : borrow in from the previous (less significant) digit
//   d    : DIGIT-bit difference slice
//   bout : borrow out to the next digit
// A serial adder can reuse this cell by feeding ~y and treating the
// borrow as an inverted carry.
module sub_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    // One extra bit catches the sign of the raw difference: it is set
    // exactly when x - y - bin went negative.
    logic [DIGIT:0] t;

    assign t    = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bin};
    assign d    = t[DIGIT-1:0];
    assign bout = t[DIGIT];

endmodule

// File: rtl/serial_sub8.sv
// Digit-serial subtractor: diff = (a - b) mod 2^WIDTH, DIGIT bits per cycle.
//   clk, rst_n : rising-edge clock, async active-low reset
//   start      : request, sampled only while idle
//   a, b       : operands, captured on an accepted start
//   diff       : result, held until the next operation finishes
//   borrow     : a < b unsigned
//   ovf        : signed overflow of the subtraction
//   zero       : diff == 0
//   busy       : operation in progress (RUN and DONE states)
//   done       : one-cycle pulse when diff/flags are fresh
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// RUN   | one digit per cycle, LSB digit first
// DONE  | publish diff and flags, pulse done
module serial_sub8
    import sub8_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int N  = digits(WIDTH, DIGIT);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             bin_r;
    logic [CW-1:0]    cnt;
    // Operand MSBs kept aside: sa/sb are shifted away during RUN.
    logic [1:0]       msb;

    logic [DIGIT-1:0] d_dig;
    logic             bout;
    logic [WIDTH-1:0] res_next;

    sub_digit #(.DIGIT(DIGIT)) u_dig (
        .x    (sa[DIGIT-1:0]),
        .y    (sb[DIGIT-1:0]),
        .bin  (bin_r),
        .d    (d_dig),
        .bout (bout)
    );

    // New digit enters at the top; after N shifts the LSB digit lands at bit 0.
    // Written as shifts so DIGIT == WIDTH needs no special case.
    assign res_next = (res >> DIGIT) | (WIDTH'(d_dig) << (WIDTH - DIGIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            bin_r  <= 1'b0;
            cnt    <= '0;
            msb    <= 2'b00;
            diff   <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        msb   <= {a[WIDTH-1], b[WIDTH-1]};
                        res   <= '0;
                        bin_r <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res   <= res_next;
                    sa    <= sa >> DIGIT;
                    sb    <= sb >> DIGIT;
                    bin_r <= bout;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    diff   <= res;
                    borrow <= bin_r;
                    ovf    <= (msb[1] != msb[0]) && (res[WIDTH-1] != msb[1]);
                    zero   <= (res == '0);
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub8.sv
// Directed bench for serial_sub8. Four instances cover DIGIT = 1, 2, 4, 8;
// directed cases run on the DIGIT=2 instance (index 1).
module tb_serial_sub8;

    logic       clk;
    logic       rst_n;
    logic [3:0] start_v;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff_v   [4];
    logic       borrow_v [4];
    logic       ovf_v    [4];
    logic       zero_v   [4];
    logic       busy_v   [4];
    logic       done_v   [4];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        serial_sub8 #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .start  (start_v[g]),
            .a      (a),
            .b      (b),
            .diff   (diff_v[g]),
            .borrow (borrow_v[g]),
            .ovf    (ovf_v[g]),
            .zero   (zero_v[g]),
            .busy   (busy_v[g]),
            .done   (done_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for done on instance k; cyc counts edges after the start edge.
    task automatic wait_done(input int k, output int cyc);
        cyc = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (done_v[k] === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic run_op(input int k, input logic [7:0] av, input logic [7:0] bv,
                          output int lat);
        a = av;
        b = bv;
        start_v[k] = 1'b1;
        tick();
        start_v[k] = 1'b0;
        wait_done(k, lat);
    endtask

    initial begin
        int         lat;
        int         ndone;
        int         t1;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] rs;

        rst_n   = 1'b0;
        start_v = 4'b0;
        a       = 8'h00;
        b       = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_diff", diff_v[1], 0);
        check("rst_flags", {borrow_v[1], ovf_v[1], zero_v[1], busy_v[1], done_v[1]}, 0);

        // Basic
        run_op(1, 8'h5A, 8'h23, lat);
        check("basic_lat", lat, 5);
        check("basic_diff", diff_v[1], 8'h37);
        check("basic_flags", {borrow_v[1], ovf_v[1], zero_v[1], busy_v[1]}, 4'b0000);
        tick();
        check("done_pulse_width", done_v[1], 0);

        // Borrow
        run_op(1, 8'h10, 8'h20, lat);
        check("borrow_diff", diff_v[1], 8'hF0);
        check("borrow_flags", {borrow_v[1], ovf_v[1], zero_v[1]}, 3'b100);

        // Zero
        run_op(1, 8'h7F, 8'h7F, lat);
        check("zero_diff", diff_v[1], 8'h00);
        check("zero_flags", {borrow_v[1], ovf_v[1], zero_v[1]}, 3'b001);

        // Signed overflow
        run_op(1, 8'h80, 8'h01, lat);
        check("ovf1_diff", diff_v[1], 8'h7F);
        check("ovf1_flags", {borrow_v[1], ovf_v[1], zero_v[1]}, 3'b010);
        run_op(1, 8'h7F, 8'hFF, lat);
        check("ovf2_diff", diff_v[1], 8'h80);
        check("ovf2_flags", {borrow_v[1], ovf_v[1], zero_v[1]}, 3'b110);

        // Start while busy is ignored; result stays held afterwards
        a = 8'h09;
        b = 8'h03;
        start_v[1] = 1'b1;
        tick();
        start_v[1] = 1'b0;
        tick();
        a = 8'hFF;
        start_v[1] = 1'b1;
        tick();
        start_v[1] = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done_v[1] === 1'b1) ndone++;
        end
        check("busy_start_dones", ndone, 1);
        check("busy_start_diff", diff_v[1], 8'h06);
        check("busy_start_idle", busy_v[1], 0);

        // Start held high: a new op every WIDTH/DIGIT+2 cycles
        a = 8'h30;
        b = 8'h10;
        start_v[1] = 1'b1;
        wait_done(1, t1);
        wait_done(1, lat);
        start_v[1] = 1'b0;
        check("held_start_gap", lat, 6);
        check("held_start_diff", diff_v[1], 8'h20);
        for (int i = 0; i < 8; i++) tick();

        // Reset mid-RUN
        a = 8'h55;
        b = 8'h11;
        start_v[1] = 1'b1;
        tick();
        start_v[1] = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_diff", diff_v[1], 0);
        check("midrst_flags", {borrow_v[1], ovf_v[1], zero_v[1], busy_v[1], done_v[1]}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done_v[1] === 1'b1) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        check("midrst_diff_after", diff_v[1], 0);

        // Cross-check against addition for every digit size
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 4; n++) begin
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
                if (n == 0) begin
                    ra = 8'h00;
                    rb = 8'hFF;
                end
                rs = ra + rb;
                run_op(k, rs, rb, lat);
                check($sformatf("xchk_d%0d_lat", 1 << k), lat, 8 / (1 << k) + 1);
                check($sformatf("xchk_d%0d_diff", 1 << k), diff_v[k], ra);
                check($sformatf("xchk_d%0d_borrow", 1 << k), borrow_v[k], (rs < rb) ? 1 : 0);
                check($sformatf("xchk_d%0d_ovf", 1 << k), ovf_v[k],
                      ((rs[7] != rb[7]) && (ra[7] != rs[7])) ? 1 : 0);
                check($sformatf("xchk_d%0d_zero", 1 << k), zero_v[k], (ra == 8'h00) ? 1 : 0);
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
